// File: rtl/char_seq_pkg.sv
// Shared types and constants for the character sequencer: FSM state encoding,
// the idle character and the ASCII codes used by the top level and its bench.
package char_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam logic [7:0] BLANK_CHAR = 8'h00;

  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_B = 8'h42;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_Z = 8'h5A;

endpackage

// File: rtl/char_seq_if.sv
// Command/status bundle between the pin-level glue (master) and the character
// sequencer (slave): buffer writes, playback controls and display outputs.
interface char_seq_if #(
  parameter int DEPTH  = 8,
  parameter int CHAR_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CHAR_W-1:0] wr_data;
  logic [AW-1:0]     len_m1;
  logic              loop;
  logic [1:0]        dwell_sel;
  logic              start;
  logic              stop;
  logic              pause;
  logic              step;

  logic [CHAR_W-1:0] char_out;
  logic              char_valid;
  logic              busy;
  logic [AW-1:0]     idx;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, len_m1, loop, dwell_sel,
           start, stop, pause, step,
    input  char_out, char_valid, busy, idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len_m1, loop, dwell_sel,
           start, stop, pause, step,
    output char_out, char_valid, busy, idx, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle base tick every TICK_DIV enabled cycles.
// The count freezes while en is low and returns to zero on clr.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/char_seq_ctrl.sv
// Plays a programmable buffer of character codes onto a registered output,
// one entry per dwell period, with run/pause/step and loop/one-shot control.
module char_seq_ctrl
  import char_seq_pkg::*;
#(
  parameter int                DEPTH    = 8,
  parameter int                TICK_DIV = 25_000_000,
  parameter int                CHAR_W   = 8,
  parameter logic [CHAR_W-1:0] BLANK    = CHAR_W'(BLANK_CHAR)
) (
  input  logic       clk,
  input  logic       rst_n,
  char_seq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     len_q, len_d;
  logic [1:0]        dwell_q, dwell_d;
  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [CHAR_W-1:0] mem_d [DEPTH];
  logic [CHAR_W-1:0] char_out_q, char_out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic tick;
  logic presc_en;
  logic presc_clr;
  logic step_ok;
  logic adv;

  // A step only counts when no higher-priority command shares its cycle.
  assign step_ok   = (state_q == ST_PAUSE) && bus.step &&
                     !bus.stop && !bus.start && !bus.pause;
  assign presc_en  = (state_q == ST_PLAY) && !(bus.stop || bus.start || bus.pause);
  assign presc_clr = bus.stop || bus.start || step_ok;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    mem_d = mem_q;
    if (bus.wr_en) mem_d[bus.wr_addr] = bus.wr_data;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    dwell_d = dwell_q;
    adv     = 1'b0;

    if (bus.stop) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      dwell_d = '0;
    end else if (bus.start) begin
      state_d = ST_PLAY;
      len_d   = bus.len_m1;
      idx_d   = '0;
      dwell_d = '0;
    end else if (bus.pause && (state_q == ST_PLAY || state_q == ST_PAUSE)) begin
      state_d = (state_q == ST_PLAY) ? ST_PAUSE : ST_PLAY;
    end else if (step_ok) begin
      adv     = 1'b1;
      dwell_d = '0;
    end else if (state_q == ST_PLAY && tick) begin
      if (dwell_q == bus.dwell_sel) begin
        dwell_d = '0;
        adv     = 1'b1;
      end else begin
        dwell_d = dwell_q + 2'd1;
      end
    end

    if (adv) begin
      if (idx_q < len_q) idx_d = idx_q + AW'(1);
      else if (bus.loop) idx_d = '0;
      else               state_d = ST_DONE;
    end

    done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
    valid_d    = (state_q != ST_IDLE);
    // Reading the post-write buffer lets a write to the shown entry appear next cycle.
    char_out_d = valid_d ? mem_d[idx_q] : BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      dwell_q    <= '0;
      char_out_q <= BLANK;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      dwell_q    <= dwell_d;
      char_out_q <= char_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // NOTE: the buffer is small and must read as zero after reset, so it is built
  // from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bus.char_out   = char_out_q;
  assign bus.char_valid = valid_q;
  assign bus.busy       = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
  assign bus.idx        = idx_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_char_seq_ctrl.sv
// Directed bench for char_seq_ctrl with a fast prescaler: table-driven one-shot
// playback plus hand-written loop, pause, step, stop/start, reset and write cases.
module tb_char_seq_ctrl;
  import char_seq_pkg::*;

  localparam int DEPTH    = 8;
  localparam int TICK_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  char_seq_if #(.DEPTH(DEPTH), .CHAR_W(8)) bus ();

  char_seq_ctrl #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .CHAR_W   (8),
    .BLANK    (BLANK_CHAR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       pause;
    logic       step;
    logic [7:0] ch;
    logic       valid;
    logic       busy;
    logic [2:0] idx;
    logic       done;
  } vec_t;

  vec_t t1 [15];

  function automatic vec_t mk(logic st, logic [7:0] ch, logic v, logic b,
                              logic [2:0] i, logic d);
    vec_t r;
    r.start = st; r.stop = 1'b0; r.pause = 1'b0; r.step = 1'b0;
    r.ch = ch; r.valid = v; r.busy = b; r.idx = i; r.done = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] ch, input logic v,
                            input logic b, input logic [2:0] i, input logic d);
    check({tag, ".char_out"},   bus.char_out,   ch);
    check({tag, ".char_valid"}, bus.char_valid, v);
    check({tag, ".busy"},       bus.busy,       b);
    check({tag, ".idx"},        bus.idx,        i);
    check({tag, ".done"},       bus.done,       d);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    cyc();
    bus.wr_en = 1'b0;
  endtask

  task automatic write_abc();
    wr(3'd0, CH_A);
    wr(3'd1, CH_B);
    wr(3'd2, CH_C);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  logic [7:0] abc [3];

  initial begin
    abc[0] = CH_A; abc[1] = CH_B; abc[2] = CH_C;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.len_m1 = 3'd2; bus.loop = 0; bus.dwell_sel = 2'd0;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.step = 0;

    // Test 1 expectations: one row per clock, sampled just after the edge.
    t1[0] = mk(1, 8'h00, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++)  t1[k] = mk(0, CH_A, 1, 1, 0, 0);
    t1[4] = mk(0, CH_A, 1, 1, 1, 0);
    for (int k = 5; k <= 7; k++)  t1[k] = mk(0, CH_B, 1, 1, 1, 0);
    t1[8] = mk(0, CH_B, 1, 1, 2, 0);
    for (int k = 9; k <= 11; k++) t1[k] = mk(0, CH_C, 1, 1, 2, 0);
    t1[12] = mk(0, CH_C, 1, 0, 2, 1);
    t1[13] = mk(0, CH_C, 1, 0, 2, 0);
    t1[14] = mk(0, CH_C, 1, 0, 2, 0);

    #2 rst_n = 1'b0;
    #1 check_outs("reset", BLANK_CHAR, 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_outs("idle", BLANK_CHAR, 0, 0, 0, 0);

    // 1: one-shot ABC, dwell 1 tick
    write_abc();
    check("idle_after_wr.char_out", bus.char_out, BLANK_CHAR);
    for (int r = 0; r < 15; r++) begin
      bus.start = t1[r].start; bus.stop = t1[r].stop;
      bus.pause = t1[r].pause; bus.step = t1[r].step;
      cyc();
      check_outs($sformatf("oneshot[%0d]", r), t1[r].ch, t1[r].valid, t1[r].busy,
                 t1[r].idx, t1[r].done);
    end
    bus.start = 0;

    // 2: loop mode, 2 ticks per char -> 8 cycles per char
    bus.loop = 1'b1; bus.dwell_sel = 2'd1;
    pulse_start();
    check("loop_start.done", bus.done, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      cyc();
      check($sformatf("loop[%0d].char_out", k), bus.char_out, abc[((k - 1) / 8) % 3]);
      check($sformatf("loop[%0d].done", k), bus.done, 1'b0);
    end

    // 3: pause during the 2nd cycle of B, hold 20 cycles, resume
    bus.dwell_sel = 2'd0;
    pulse_start();
    repeat (6) cyc();
    check_outs("pre_pause", CH_B, 1, 1, 1, 0);
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    check_outs("paused", CH_B, 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      check($sformatf("pause_hold[%0d].char_out", k), bus.char_out, CH_B);
      check($sformatf("pause_hold[%0d].idx", k), bus.idx, 3'd1);
    end
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    check_outs("resume0", CH_B, 1, 1, 1, 0);
    cyc(); check_outs("resume1", CH_B, 1, 1, 1, 0);
    cyc(); check_outs("resume2", CH_B, 1, 1, 2, 0);
    cyc(); check_outs("resume3", CH_C, 1, 1, 2, 0);

    // 4: single-step through a one-shot message while paused
    bus.loop = 1'b0;
    pulse_start();
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    repeat (5) cyc();
    check_outs("step_wait", CH_A, 1, 1, 0, 0);
    bus.step = 1'b1; cyc(); bus.step = 1'b0;
    check_outs("step1", CH_A, 1, 1, 1, 0);
    repeat (5) cyc();
    check_outs("step1_hold", CH_B, 1, 1, 1, 0);
    bus.step = 1'b1; cyc(); bus.step = 1'b0;
    check_outs("step2", CH_B, 1, 1, 2, 0);
    cyc();
    check_outs("step2_hold", CH_C, 1, 1, 2, 0);
    bus.step = 1'b1; cyc(); bus.step = 1'b0;
    check_outs("step3_done", CH_C, 1, 0, 2, 1);
    cyc();
    check_outs("step3_after", CH_C, 1, 0, 2, 0);

    // 5: start and stop together -> stop wins; start alone restarts
    bus.loop = 1'b1;
    pulse_start();
    repeat (5) cyc();
    bus.start = 1'b1; bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    check("stop_win.busy", bus.busy, 1'b0);
    check("stop_win.idx", bus.idx, 3'd0);
    check("stop_win.done", bus.done, 1'b0);
    cyc(); bus.start = 1'b0;
    check_outs("stop_idle", BLANK_CHAR, 0, 1, 0, 0);
    cyc();
    check_outs("restart", CH_A, 1, 1, 0, 0);

    // len_m1 = 0: single-entry one-shot finishes after one dwell
    bus.loop = 1'b0; bus.len_m1 = 3'd0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("len1[%0d].done", k), bus.done, 1'b0);
    end
    cyc();
    check_outs("len1_done", CH_A, 1, 0, 0, 1);
    bus.len_m1 = 3'd2;

    // 6: asynchronous reset mid-dwell
    bus.loop = 1'b1;
    pulse_start();
    repeat (6) cyc();
    check("pre_rst.idx", bus.idx, 3'd1);
    #3 rst_n = 1'b0;
    #1 check_outs("async_rst", BLANK_CHAR, 0, 0, 0, 0);
    cyc();
    check_outs("rst_held", BLANK_CHAR, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check($sformatf("post_rst[%0d].done", k), bus.done, 1'b0);
      check($sformatf("post_rst[%0d].busy", k), bus.busy, 1'b0);
    end

    // Buffer was cleared by reset: an unwritten run shows zero codes
    pulse_start();
    cyc();
    check_outs("cleared_buf", 8'h00, 1, 1, 0, 0);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;

    // Write to the displayed entry during PLAY
    write_abc();
    pulse_start();
    cyc();
    check_outs("wr_live_before", CH_A, 1, 1, 0, 0);
    wr(3'd0, CH_Z);
    check_outs("wr_live_after", CH_Z, 1, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/char_seq_ctrl.md
Name: char_seq_ctrl

Overview:
Controller that sequences the character display output. It holds a small programmable message buffer of 8-bit character codes and plays it back one character per dwell period, derived from a prescaled clock tick. It supports run, pause, single-step, loop and one-shot modes. It sits between the top-level ui_in/uio_in pins and the uo_out character bus, and replaces the free-running fixed-table sequencing.

Parameters:
DEPTH, 8, number of buffer entries (power of two, 2..16)
TICK_DIV, 25_000_000, clk cycles per base tick (>=2)
CHAR_W, 8, character code width
BLANK, 8'h00, char_out value when not playing

Ports:
clk  input  1  system clock
rst_n  input  1  reset
wr_en  input  1  buffer write strobe
wr_addr  input  clog2(DEPTH)  buffer write index
wr_data  input  CHAR_W  character code to write
len_m1  input  clog2(DEPTH)  message length minus one; sampled on start
loop  input  1  1=wrap to entry 0 after last, 0=one-shot
dwell_sel  input  2  ticks per character = dwell_sel+1
start  input  1  start/restart playback (level-sampled each cycle)
stop  input  1  abort to IDLE
pause  input  1  toggle PLAY<->PAUSE (single-cycle pulse expected)
step  input  1  advance one entry while PAUSE
char_out  output  CHAR_W  registered character code
char_valid  output  1  char_out shows a buffer entry
busy  output  1  state is PLAY or PAUSE
idx  output  clog2(DEPTH)  current entry index
done  output  1  one-cycle pulse at one-shot completion

Behaviour:
- One clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state IDLE, idx 0, tick/dwell counters 0, len register 0, buffer all 0, char_out BLANK, char_valid 0, busy 0, done 0. Reset mid-playback aborts immediately; no done pulse.
- States: IDLE, PLAY, PAUSE, DONE.
- Command priority per cycle: stop > start > pause > step. Lower-priority commands in the same cycle are ignored.
- stop (any state): go to IDLE, idx 0, counters 0.
- start (any state except when stop is asserted): latch len_m1, idx 0, counters 0, go to PLAY. A restart from PLAY or PAUSE is legal.
- pause: PLAY->PAUSE or PAUSE->PLAY. Counters are frozen in PAUSE and resume from their frozen values. Ignored in IDLE and DONE.
- step: in PAUSE only, advance idx immediately using the advance rule; tick/dwell counters are reset to 0. Ignored in other states.
- Tick: in PLAY, tick_cnt counts 0..TICK_DIV-1 and wraps. Tick is asserted in the wrap cycle.
- Dwell: on tick, if dwell_cnt == dwell_sel then dwell_cnt<=0 and advance; otherwise increment dwell_cnt. dwell_sel is read live.
- Advance rule:
  - idx < len: idx+1.
  - idx == len and loop=1: idx<=0.
  - idx == len and loop=0: state DONE, done=1 for exactly one cycle, idx held.
  - A step at the last entry with loop=0 also enters DONE and pulses done.
- char_out: registered. In PLAY, PAUSE and DONE it equals buf[idx] one cycle after idx or buf changes; char_valid=1. In IDLE it is BLANK; char_valid=0.
- Writes: accepted in every state. A write to the entry currently displayed is visible on char_out the following cycle.
- len_m1 >= DEPTH cannot occur because of the port width. len_m1=0 means a single-entry message.
- busy is combinational from state: 1 in PLAY or PAUSE.

Decomposition:
- Shared package char_seq_pkg holds the state enum (IDLE, PLAY, PAUSE, DONE), the BLANK default and the ASCII constants used by the top level and the bench.
- One sub-module: tick_prescaler. It takes parameter TICK_DIV and inputs en and clr, and outputs a tick pulse. The FSM, dwell counter and buffer stay in char_seq_ctrl.

Test Plan:
1. TICK_DIV=4. Write "A","B","C" to entries 0-2; len_m1=2, loop=0, dwell_sel=0; pulse start. Required: char_out 41,42,43, each held 4 cycles; done pulses once; state DONE; char_out stays 43.
2. Same buffer with loop=1 and dwell_sel=1. Required: each char held 8 cycles; sequence 41,42,43,41...; done never asserts.
3. Pause at the 2nd cycle of "B", wait 20 cycles, pause again. Required: char_out frozen at 42 for the full pause; "B" then completes its remaining 2 cycles.
4. While PAUSE: step x3 with len_m1=2, loop=0. Required: idx goes 1->2; third step enters DONE and done pulses once.
5. Assert start and stop in the same cycle during PLAY. Required: IDLE, char_out 00, busy 0. Next cycle, start alone restarts at idx 0 and shows 41.
6. Drop rst_n asynchronously mid-dwell. Required: all outputs at reset values within the same cycle and no done pulse. Also: during PLAY, write 5A to the entry currently displayed; required char_out=5A on the next cycle.
